param_johnson_counter: RTL and testbench

PARAM_JOHNSON_COUNTER -- requirements
Module: param_johnson_counter

---
 rtl/param_johnson_pkg.sv | 13 +
 rtl/johnson_phase_decode.sv | 42 ++++
 rtl/param_johnson_counter.sv | 90 +++++++++
 tb/tb_param_johnson_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/param_johnson_pkg.sv
// Shared types and limits for the parameterised Johnson counter.
// Step direction encoding and the supported register width range.
package param_johnson_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of a Johnson code into its sequence index (one-hot)
// and a legality flag. No registers; zero latency from i_count.
module johnson_phase_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   i_count,
  output logic [2*WIDTH-1:0] o_phase,
  output logic               o_valid
);

  int w_ones;
  int w_trans;
  int w_index;

  always_comb begin
    w_ones  = 0;
    w_trans = 0;
    w_index = 0;
    o_phase = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_count[i]) w_ones = w_ones + 1;
    end
    // Legal codes are one contiguous run of ones touching either end,
    // i.e. at most one 0/1 boundary between neighbouring bits.
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (i_count[i] != i_count[i+1]) w_trans = w_trans + 1;
    end
    o_valid = (w_trans <= 1);
    // Run anchored at bit 0 counts up; run anchored at the top counts down.
    if (i_count[0]) begin
      w_index = w_ones;
    end else if (w_ones == 0) begin
      w_index = 0;
    end else begin
      w_index = 2 * WIDTH - w_ones;
    end
    for (int i = 0; i < 2 * WIDTH; i++) begin
      o_phase[i] = o_valid && (w_index == i);
    end
  end

endmodule

// File: rtl/param_johnson_counter.sv
// Bidirectional Johnson counter with synchronous load, optional
// self-correction of illegal codes, and registered wrap/err pulses.
module param_johnson_counter
  import param_johnson_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int SELF_CORRECT = 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               preset,
  input  logic [WIDTH-1:0]   load_cnt,
  input  logic               enable,
  input  logic               dir,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               valid,
  output logic               wrap,
  output logic               err
);

  localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam bit               SC_ON     = (SELF_CORRECT != 0);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  dir_t             w_dir;
  logic             w_valid;
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_rev;
  logic [WIDTH-1:0] w_step;
  logic             w_wrap_step;
  logic             w_correct;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;

  johnson_phase_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .i_count(r_count),
    .o_phase(phase),
    .o_valid(w_valid)
  );

  assign w_dir     = dir_t'(dir);
  assign w_fwd     = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
  assign w_rev     = {~r_count[0], r_count[WIDTH-1:1]};
  assign w_step    = (w_dir == DIR_FWD) ? w_fwd : w_rev;
  assign w_correct = SC_ON && !w_valid;

  // Wrap is the crossing between the last index and index 0 in either direction.
  assign w_wrap_step = (w_dir == DIR_FWD) ? (r_count == LAST_CODE)
                                          : (r_count == '0);

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (!preset) begin
      w_count_nxt = load_cnt;
    end else if (w_correct) begin
      w_count_nxt = '0;
      w_err_nxt   = 1'b1;
    end else if (enable) begin
      w_count_nxt = w_step;
      w_wrap_nxt  = w_wrap_step;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign count = r_count;
  assign valid = w_valid;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_param_johnson_counter.sv
// Scoreboard bench for param_johnson_counter: three instances (W4 corrected,
// W4 uncorrected, W8 corrected) share controls; expectations queue per edge.
module tb_param_johnson_counter;

  localparam int ENT_W = 29;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       preset = 1'b1;
  logic [3:0] load4 = '0;
  logic [7:0] load8 = '0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic       chk = 1'b0;

  logic [3:0]  count_a, count_b;
  logic [7:0]  phase_a, phase_b;
  logic        valid_a, valid_b, wrap_a, wrap_b, err_a, err_b;
  logic [7:0]  count_c;
  logic [15:0] phase_c;
  logic        valid_c, wrap_c, err_c;

  logic [ENT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  param_johnson_counter #(.WIDTH(4), .SELF_CORRECT(1)) dut_a (
    .clk(clk), .clear(clear), .preset(preset), .load_cnt(load4),
    .enable(enable), .dir(dir), .count(count_a), .phase(phase_a),
    .valid(valid_a), .wrap(wrap_a), .err(err_a)
  );

  param_johnson_counter #(.WIDTH(4), .SELF_CORRECT(0)) dut_b (
    .clk(clk), .clear(clear), .preset(preset), .load_cnt(load4),
    .enable(enable), .dir(dir), .count(count_b), .phase(phase_b),
    .valid(valid_b), .wrap(wrap_b), .err(err_b)
  );

  param_johnson_counter #(.WIDTH(8), .SELF_CORRECT(1)) dut_c (
    .clk(clk), .clear(clear), .preset(preset), .load_cnt(load8),
    .enable(enable), .dir(dir), .count(count_c), .phase(phase_c),
    .valid(valid_c), .wrap(wrap_c), .err(err_c)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected entry: {tag, count, phase, valid, wrap, err}; k < 0 means illegal
  task automatic exp_push(input logic [1:0] tag, input logic [7:0] cnt,
                          input int k, input logic w, input logic e);
    logic [15:0] ph;
    ph = (k >= 0) ? (16'd1 << k) : 16'd0;
    exp_q.push_back({tag, cnt, ph, (k >= 0), w, e});
  endtask

  task automatic exp_ab(input logic [3:0] cnt, input int k, input logic w, input logic e);
    exp_push(2'd0, {4'h0, cnt}, k, w, e);
    exp_push(2'd1, {4'h0, cnt}, k, w, e);
  endtask

  task automatic drive(input logic pre, input logic [3:0] ld, input logic en, input logic dr);
    @(negedge clk);
    preset = pre;
    load4  = ld;
    load8  = {4'h0, ld};
    enable = en;
    dir    = dr;
  endtask

  task automatic strobe_check();
    #1 chk = 1'b1;
    #1 chk = 1'b0;
  endtask

  // monitor: drains every queued expectation after each edge or async strobe
  initial begin : monitor
    logic [ENT_W-1:0] e;
    logic [ENT_W-1:0] act;
    forever begin
      @(posedge clk or posedge chk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e[28:27])
          2'd0:    act = {2'd0, 4'h0, count_a, 8'h0, phase_a, valid_a, wrap_a, err_a};
          2'd1:    act = {2'd1, 4'h0, count_b, 8'h0, phase_b, valid_b, wrap_b, err_b};
          default: act = {2'd2, count_c, phase_c, valid_c, wrap_c, err_c};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL dut%0d @%0t: got cnt=%h ph=%h v=%b w=%b e=%b, exp cnt=%h ph=%h v=%b w=%b e=%b",
                   e[28:27], $time, act[26:19], act[18:3], act[2], act[1], act[0],
                   e[26:19], e[18:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // driver / stimulus
  initial begin : driver
    logic [3:0] fwd4 [8];
    logic [7:0] fwd8 [16];
    fwd4 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    fwd8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
             8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

    // clear asserted: immediate reset values on all instances
    #1 clear = 1'b0;
    exp_ab(4'b0000, 0, 1'b0, 1'b0);
    exp_push(2'd2, 8'h00, 0, 1'b0, 1'b0);
    strobe_check();

    // clock running with clear held low
    repeat (2) begin
      drive(1'b1, 4'h0, 1'b1, 1'b0);
      exp_ab(4'b0000, 0, 1'b0, 1'b0);
    end

    // forward run of 8 steps; first edge after release already steps
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'h0, 1'b1, 1'b0);
      if (i == 0) clear = 1'b1;
      exp_ab(fwd4[i], (i + 1) % 8, (i == 7), 1'b0);
    end

    // reverse from 0 wraps, then a direction flip takes effect immediately
    drive(1'b1, 4'h0, 1'b1, 1'b1); exp_ab(4'b1000, 7, 1'b1, 1'b0);
    drive(1'b1, 4'h0, 1'b1, 1'b1); exp_ab(4'b1100, 6, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b1, 1'b0); exp_ab(4'b1000, 7, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 1'b0); exp_ab(4'b1000, 7, 1'b0, 1'b0);

    // load wins over enable; load of last code then forward wrap
    drive(1'b0, 4'b0011, 1'b1, 1'b1); exp_ab(4'b0011, 2, 1'b0, 1'b0);
    drive(1'b0, 4'b1000, 1'b0, 1'b0); exp_ab(4'b1000, 7, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b1, 1'b0);    exp_ab(4'b0000, 0, 1'b1, 1'b0);

    // illegal load: correction with enable low vs uncorrected hold/shift
    drive(1'b0, 4'b0101, 1'b0, 1'b0); exp_ab(4'b0101, -1, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    exp_push(2'd0, 8'h00, 0, 1'b0, 1'b1);
    exp_push(2'd1, 8'h05, -1, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b1, 1'b0);
    exp_push(2'd0, 8'h01, 1, 1'b0, 1'b0);
    exp_push(2'd1, 8'h0B, -1, 1'b0, 1'b0);

    // correction beats an enabled reverse step
    drive(1'b0, 4'b0110, 1'b1, 1'b0); exp_ab(4'b0110, -1, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b1, 1'b1);
    exp_push(2'd0, 8'h00, 0, 1'b0, 1'b1);
    exp_push(2'd1, 8'h0B, -1, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    exp_push(2'd0, 8'h00, 0, 1'b0, 1'b0);
    exp_push(2'd1, 8'h0B, -1, 1'b0, 1'b0);

    // clear pulse between edges at 0111
    drive(1'b0, 4'b0111, 1'b0, 1'b0); exp_ab(4'b0111, 3, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    clear = 1'b0;
    exp_ab(4'b0000, 0, 1'b0, 1'b0);
    exp_push(2'd2, 8'h00, 0, 1'b0, 1'b0);
    strobe_check();
    #1 clear = 1'b1;
    exp_ab(4'b0000, 0, 1'b0, 1'b0);
    exp_push(2'd2, 8'h00, 0, 1'b0, 1'b0);

    // 8-bit forward run: 16 states, single wrap, then restart at index 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 4'h0, 1'b1, 1'b0);
      exp_push(2'd2, fwd8[i % 16], (i + 1) % 16, (i == 15), 1'b0);
    end

    // bounded drain of the scoreboard
    drive(1'b1, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, exp 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
